// File: rtl/controlador_display.sv
//------------------------------------------------------------------------------
// controlador_display: time-multiplexed scan controller for an N-digit
// common-anode 7-segment display with tear-free load handshake.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module controlador_display #(
  parameter int N_DIGITOS = 4,
  parameter int DIV       = 50000,
  parameter int ANCHO_DIV = 16
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic [4*N_DIGITOS-1:0] dato,
  input  logic                   cargar,
  input  logic                   blanco_ceros,
  output logic [3:0]             nibble,
  output logic [2:0]             digito_act,
  output logic [N_DIGITOS-1:0]   anodos,
  output logic                   listo
);

  localparam logic [0:0]           ESPERA  = 1'b0;
  localparam logic [0:0]           BARRIDO = 1'b1;
  localparam logic [ANCHO_DIV-1:0] DIV_MAX = ANCHO_DIV'(DIV - 1);
  localparam logic [2:0]           ULTIMO  = 3'(N_DIGITOS - 1);

  logic [0:0]             estado_q, estado_d;
  logic [ANCHO_DIV-1:0]   div_q, div_d;
  logic [2:0]             digito_q, digito_d;
  logic [3:0]             nibble_q, nibble_d;
  logic [N_DIGITOS-1:0]   anodos_q, anodos_d;
  logic                   listo_q, listo_d;
  logic [4*N_DIGITOS-1:0] visible_q, visible_d;
  logic [4*N_DIGITOS-1:0] shadow_q, shadow_d;
  logic [N_DIGITOS-1:0]   apagado;
  logic                   todo_cero;
  logic                   cierre_marco;

  always_comb begin
    estado_d     = estado_q;
    div_d        = div_q;
    digito_d     = digito_q;
    listo_d      = listo_q;
    visible_d    = visible_q;
    shadow_d     = shadow_q;
    cierre_marco = 1'b0;
    case (estado_q)
      ESPERA: begin
        div_d = '0;
        if (cargar) begin
          visible_d = dato;
          digito_d  = '0;
          estado_d  = BARRIDO;
        end
      end
      BARRIDO: begin
        if (div_q == DIV_MAX) begin
          div_d        = '0;
          cierre_marco = (digito_q == ULTIMO);
          digito_d     = cierre_marco ? 3'd0 : digito_q + 3'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
        // A pending value lands together with the wrap to digit 0, so a frame never mixes old and new.
        if (!listo_q) begin
          if (cierre_marco) begin
            visible_d = shadow_q;
            listo_d   = 1'b1;
          end
        end else if (cargar) begin
          shadow_d = dato;
          listo_d  = 1'b0;
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_comb begin
    nibble_d = '0;
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (int'(digito_d) == k) nibble_d = visible_d[4*k +: 4];
    end
  end

  // Anodes follow the digit shown last cycle, matching the translator's one-cycle latency.
  always_comb begin
    todo_cero = 1'b1;
    apagado   = '0;
    for (int k = N_DIGITOS - 1; k >= 0; k--) begin
      todo_cero  = todo_cero & (visible_q[4*k +: 4] == 4'h0);
      apagado[k] = blanco_ceros & todo_cero & (k != 0);
    end
    anodos_d = '1;
    if (estado_q == BARRIDO) begin
      for (int k = 0; k < N_DIGITOS; k++) begin
        if (int'(digito_q) == k && !apagado[k]) anodos_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q  <= ESPERA;
      div_q     <= '0;
      digito_q  <= '0;
      nibble_q  <= '0;
      anodos_q  <= '1;
      listo_q   <= 1'b1;
      visible_q <= '0;
      shadow_q  <= '0;
    end else begin
      estado_q  <= estado_d;
      div_q     <= div_d;
      digito_q  <= digito_d;
      nibble_q  <= nibble_d;
      anodos_q  <= anodos_d;
      listo_q   <= listo_d;
      visible_q <= visible_d;
      shadow_q  <= shadow_d;
    end
  end

  assign nibble     = nibble_q;
  assign digito_act = digito_q;
  assign anodos     = anodos_q;
  assign listo      = listo_q;

endmodule

`default_nettype wire
